mems_dac_sequencer: RTL and testbench



---
 rtl/mems_dac_sequencer_if.sv | 26 ++
 rtl/mems_dac_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_mems_dac_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mems_dac_sequencer_if.sv
// Mirror-axis request/ack handshakes and the frame port toward the 24-bit SPI master.
// The sequencer uses the master view; requesters and the SPI master use the slave view.
interface mems_dac_sequencer_if;
  logic        req_x;
  logic [15:0] x_data;
  logic        ack_x;
  logic        req_y;
  logic [15:0] y_data;
  logic        ack_y;
  logic [23:0] spi_data;
  logic        spi_start;
  logic        spi_busy;
  logic        spi_done;
  logic        ready;
  logic        err_timeout;

  modport master (
    input  req_x, x_data, req_y, y_data, spi_busy, spi_done,
    output ack_x, ack_y, spi_data, spi_start, ready, err_timeout
  );

  modport slave (
    output req_x, x_data, req_y, y_data, spi_busy, spi_done,
    input  ack_x, ack_y, spi_data, spi_start, ready, err_timeout
  );
endinterface

// File: rtl/mems_dac_sequencer.sv
// DAC frame sequencer for the MEMS mirror driver: init sequence, then X/Y code updates,
// with paired updates latched together by a trailing write-and-update-all frame.
module mems_dac_sequencer #(
  parameter logic [2:0]  ADDR_X           = 3'b000,
  parameter logic [2:0]  ADDR_Y           = 3'b001,
  parameter logic [2:0]  CMD_WRITE        = 3'b000,
  parameter logic [2:0]  CMD_WRITE_UPDATE = 3'b010,
  parameter logic [23:0] INIT_FRAME_0     = 24'h280001,
  parameter logic [23:0] INIT_FRAME_1     = 24'h380001,
  parameter int          GAP_CYCLES       = 4,
  parameter int          TIMEOUT_CYCLES   = 2048
) (
  input logic                  clk,
  input logic                  rst,
  mems_dac_sequencer_if.master bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    GAP       = 3'd3,
    IDLE      = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             pend_y, pend_y_nxt;
  logic             init_sel, init_sel_nxt;
  logic             init_fail, init_fail_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic [23:0]      spi_data_r, data_nxt;
  logic             spi_start_r, start_nxt;
  logic             ack_x_r, ack_x_nxt;
  logic             ack_y_r, ack_y_nxt;
  logic             ready_r, ready_nxt;
  logic             err_r, err_nxt;

  function automatic logic [23:0] make_frame(input logic [2:0]  cmd,
                                             input logic [2:0]  addr,
                                             input logic [15:0] code);
    return {2'b00, cmd, addr, code};
  endfunction

  // Every transition into ISSUE loads the frame, the start pulse and any ack together,
  // so the registered outputs appear in the single ISSUE cycle.
  always_comb begin
    state_nxt     = state;
    pend_y_nxt    = pend_y;
    init_sel_nxt  = init_sel;
    init_fail_nxt = init_fail;
    gap_cnt_nxt   = gap_cnt;
    to_cnt_nxt    = to_cnt;
    data_nxt      = spi_data_r;
    start_nxt     = 1'b0;
    ack_x_nxt     = 1'b0;
    ack_y_nxt     = 1'b0;
    ready_nxt     = ready_r;
    err_nxt       = err_r;

    unique case (state)
      INIT: begin
        if (!bus.spi_busy) begin
          data_nxt     = INIT_FRAME_0;
          start_nxt    = 1'b1;
          init_sel_nxt = 1'b0;
          to_cnt_nxt   = '0;
          state_nxt    = ISSUE;
        end
      end

      ISSUE: begin
        to_cnt_nxt = to_cnt + 1'b1;
        state_nxt  = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (bus.spi_done) begin
          gap_cnt_nxt = '0;
          state_nxt   = GAP;
        end else if (to_cnt == TO_LAST) begin
          err_nxt     = 1'b1;
          gap_cnt_nxt = '0;
          state_nxt   = GAP;
          if (!ready_r) init_fail_nxt = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end

      // The counter parks on its last value while the SPI master is still busy.
      GAP: begin
        if (gap_cnt != GAP_LAST) begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end else if (!ready_r) begin
          if (init_fail) begin
            init_fail_nxt = 1'b0;
            state_nxt     = INIT;
          end else if (!init_sel) begin
            if (!bus.spi_busy) begin
              data_nxt     = INIT_FRAME_1;
              start_nxt    = 1'b1;
              init_sel_nxt = 1'b1;
              to_cnt_nxt   = '0;
              state_nxt    = ISSUE;
            end
          end else begin
            ready_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end else if (pend_y) begin
          if (!bus.spi_busy) begin
            data_nxt   = make_frame(CMD_WRITE_UPDATE, ADDR_Y, bus.y_data);
            start_nxt  = 1'b1;
            ack_y_nxt  = 1'b1;
            pend_y_nxt = 1'b0;
            to_cnt_nxt = '0;
            state_nxt  = ISSUE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      // In a pair, X only writes its input register; the Y frame that follows updates both.
      IDLE: begin
        if (!bus.spi_busy) begin
          if (bus.req_x) begin
            data_nxt   = make_frame(bus.req_y ? CMD_WRITE : CMD_WRITE_UPDATE, ADDR_X, bus.x_data);
            start_nxt  = 1'b1;
            ack_x_nxt  = 1'b1;
            pend_y_nxt = bus.req_y;
            to_cnt_nxt = '0;
            state_nxt  = ISSUE;
          end else if (bus.req_y) begin
            data_nxt   = make_frame(CMD_WRITE_UPDATE, ADDR_Y, bus.y_data);
            start_nxt  = 1'b1;
            ack_y_nxt  = 1'b1;
            to_cnt_nxt = '0;
            state_nxt  = ISSUE;
          end
        end
      end

      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      pend_y      <= 1'b0;
      init_sel    <= 1'b0;
      init_fail   <= 1'b0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      spi_data_r  <= '0;
      spi_start_r <= 1'b0;
      ack_x_r     <= 1'b0;
      ack_y_r     <= 1'b0;
      ready_r     <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend_y      <= pend_y_nxt;
      init_sel    <= init_sel_nxt;
      init_fail   <= init_fail_nxt;
      gap_cnt     <= gap_cnt_nxt;
      to_cnt      <= to_cnt_nxt;
      spi_data_r  <= data_nxt;
      spi_start_r <= start_nxt;
      ack_x_r     <= ack_x_nxt;
      ack_y_r     <= ack_y_nxt;
      ready_r     <= ready_nxt;
      err_r       <= err_nxt;
    end
  end

  assign bus.spi_data    = spi_data_r;
  assign bus.spi_start   = spi_start_r;
  assign bus.ack_x       = ack_x_r;
  assign bus.ack_y       = ack_y_r;
  assign bus.ready       = ready_r;
  assign bus.err_timeout = err_r;

endmodule

// File: tb/tb_mems_dac_sequencer.sv
// Bench for mems_dac_sequencer: SPI-master responder, frame monitor and a transaction-level
// model that predicts each frame from the request pattern.
module tb_mems_dac_sequencer;
  localparam int GAP = 4;
  localparam int TMO = 2048;
  localparam int LAT = 60;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mems_dac_sequencer_if bus();

  mems_dac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SPI master stand-in: busy for LAT cycles after a start, then a done pulse unless hung.
  bit hang = 1'b0;
  int spi_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      bus.spi_busy <= 1'b0;
      bus.spi_done <= 1'b0;
      spi_cnt      <= 0;
    end else begin
      bus.spi_done <= 1'b0;
      if (bus.spi_start) begin
        bus.spi_busy <= 1'b1;
        spi_cnt      <= LAT;
      end else if (spi_cnt > 0) begin
        spi_cnt <= spi_cnt - 1;
        if (spi_cnt == 1) begin
          bus.spi_busy <= 1'b0;
          bus.spi_done <= !hang;
        end
      end
    end
  end

  // Monitor: records every frame and tallies protocol anomalies.
  logic [23:0] got_q[$];
  logic [1:0]  got_ack_q[$];
  int          got_cyc_q[$];
  int cyc = 0, last_done = -1, last_start = 0, ready_rise = 0, err_rise = 0;
  int min_gap = 1000000, stab_err = 0, ack_err = 0, n_ack_x = 0, n_ack_y = 0;
  bit in_flight = 1'b0, tail = 1'b0, ready_prev = 1'b0, err_prev = 1'b0;
  logic [23:0] held = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      in_flight  = 1'b0;
      tail       = 1'b0;
      last_done  = -1;
      ready_prev = 1'b0;
      err_prev   = 1'b0;
    end else begin
      if (in_flight && !bus.spi_start && bus.spi_data !== held) stab_err = stab_err + 1;
      if (tail) begin
        in_flight = 1'b0;
        tail      = 1'b0;
      end
      if (bus.spi_start) begin
        got_q.push_back(bus.spi_data);
        got_ack_q.push_back({bus.ack_y, bus.ack_x});
        got_cyc_q.push_back(cyc);
        if (last_done >= 0 && (cyc - last_done) < min_gap) min_gap = cyc - last_done;
        held       = bus.spi_data;
        in_flight  = 1'b1;
        tail       = 1'b0;
        last_start = cyc;
      end
      if (bus.spi_done) begin
        last_done = cyc;
        if (in_flight) tail = 1'b1;
      end
      if ((bus.ack_x || bus.ack_y) && !bus.spi_start) ack_err = ack_err + 1;
      if (bus.ack_x) n_ack_x = n_ack_x + 1;
      if (bus.ack_y) n_ack_y = n_ack_y + 1;
      if (bus.ready && !ready_prev) ready_rise = cyc;
      if (bus.err_timeout && !err_prev) err_rise = cyc;
      ready_prev = bus.ready;
      err_prev   = bus.err_timeout;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame = cmd*2^19 + addr*2^16 + code.
  logic [23:0] exp_q[$];
  logic [1:0]  exp_ack_q[$];
  int exp_ax = 0, exp_ay = 0, got_rd = 0;

  function automatic logic [23:0] frame_of(input int cmd, input int addr, input logic [15:0] d);
    return 24'(cmd * 524288 + addr * 65536 + int'(d));
  endfunction

  task automatic expect_raw(input logic [23:0] f, input logic [1:0] ack);
    exp_q.push_back(f);
    exp_ack_q.push_back(ack);
    if (ack[0]) exp_ax++;
    if (ack[1]) exp_ay++;
  endtask

  // Single axis: update-all (cmd 2). Pair: X write-only (cmd 0), then Y update-all.
  task automatic expect_axis(input bit is_y, input bit paired_x, input logic [15:0] d);
    if (is_y) expect_raw(frame_of(2, 1, d), 2'b10);
    else      expect_raw(frame_of(paired_x ? 0 : 2, 0, d), 2'b01);
  endtask

  task automatic compare_frames(input string tag);
    logic [23:0] e;
    logic [1:0]  ea;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ea = exp_ack_q.pop_front();
      if (got_rd < got_q.size()) begin
        chk({tag, "_frame"}, 32'(got_q[got_rd]), 32'(e));
        chk({tag, "_ack"}, 32'(got_ack_q[got_rd]), 32'(ea));
        got_rd++;
      end else begin
        chk({tag, "_frame_count"}, 32'(got_q.size()), 32'(got_rd + 1));
      end
    end
    chk({tag, "_extra_frames"}, 32'(got_q.size() - got_rd), 32'(0));
    chk({tag, "_ack_x_total"}, 32'(n_ack_x), 32'(exp_ax));
    chk({tag, "_ack_y_total"}, 32'(n_ack_y), 32'(exp_ay));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Requester: raise, hold data, drop each request on the cycle its ack is seen.
  task automatic drive_reqs(input bit dx, input bit dy, input int y_delay,
                            input logic [15:0] vx, input logic [15:0] vy,
                            output int nax, output int nay, output int lat_x);
    nax = 0; nay = 0; lat_x = -1;
    @(negedge clk);
    bus.x_data = vx;
    bus.y_data = vy;
    if (dx) bus.req_x = 1'b1;
    if (dy && y_delay == 0) bus.req_y = 1'b1;
    for (int t = 1; t <= 600; t++) begin
      @(negedge clk);
      if (bus.ack_x) begin
        nax++;
        if (lat_x < 0) lat_x = t;
        bus.req_x = 1'b0;
      end
      if (bus.ack_y) begin
        nay++;
        bus.req_y = 1'b0;
      end
      if (dy && y_delay > 0 && t == y_delay) bus.req_y = 1'b1;
      if ((!dx || nax > 0) && (!dy || nay > 0) && t > y_delay) break;
    end
    bus.req_x = 1'b0;
    bus.req_y = 1'b0;
    chk("ack_x_count", 32'(nax), 32'(dx));
    chk("ack_y_count", 32'(nay), 32'(dy));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_spi_start"}, 32'(bus.spi_start), 32'(0));
    chk({tag, "_spi_data"}, 32'(bus.spi_data), 32'(0));
    chk({tag, "_ack_x"}, 32'(bus.ack_x), 32'(0));
    chk({tag, "_ack_y"}, 32'(bus.ack_y), 32'(0));
    chk({tag, "_ready"}, 32'(bus.ready), 32'(0));
    chk({tag, "_err_timeout"}, 32'(bus.err_timeout), 32'(0));
  endtask

  task automatic check_init_timing(input string tag);
    chk({tag, "_ready"}, 32'(bus.ready), 32'(1));
    chk({tag, "_ready_after_gap"},
        32'((ready_rise - last_done) >= GAP + 1 && (ready_rise - last_done) <= GAP + 2), 32'(1));
    chk({tag, "_ready_after_frame1"}, 32'(ready_rise > got_cyc_q[got_cyc_q.size() - 1]), 32'(1));
  endtask

  initial begin
    int nax, nay, lat, kind, t0;
    logic [15:0] vx, vy;

    rst = 1'b1;
    bus.req_x = 1'b0;
    bus.req_y = 1'b0;
    bus.x_data = '0;
    bus.y_data = '0;
    step(3);
    check_reset_vals("por");

    rst = 1'b0;
    expect_raw(24'h280001, 2'b00);
    expect_raw(24'h380001, 2'b00);
    step(250);
    compare_frames("init");
    check_init_timing("init");
    chk("init_gap", 32'(min_gap >= GAP + 1), 32'(1));

    drive_reqs(1'b1, 1'b0, 0, 16'h1234, 16'h0000, nax, nay, lat);
    expect_axis(1'b0, 1'b0, 16'h1234);
    chk("x_single_latency", 32'(lat), 32'(1));
    step(150);
    compare_frames("x_single");
    chk("x_single_stable", 32'(stab_err), 32'(0));

    drive_reqs(1'b1, 1'b1, 0, 16'h1234, 16'hABCD, nax, nay, lat);
    expect_axis(1'b0, 1'b1, 16'h1234);
    expect_axis(1'b1, 1'b0, 16'hABCD);
    chk("pair_latency", 32'(lat), 32'(1));
    step(150);
    compare_frames("pair");

    vx = 16'($urandom);
    vy = 16'($urandom);
    drive_reqs(1'b1, 1'b1, 20, vx, vy, nax, nay, lat);
    expect_axis(1'b0, 1'b0, vx);
    expect_axis(1'b1, 1'b0, vy);
    step(150);
    compare_frames("y_during_x");

    for (int i = 0; i < 6; i++) begin
      kind = int'($urandom_range(0, 3));
      vx = 16'($urandom);
      vy = 16'($urandom);
      case (kind)
        0: begin
          drive_reqs(1'b1, 1'b0, 0, vx, vy, nax, nay, lat);
          expect_axis(1'b0, 1'b0, vx);
        end
        1: begin
          drive_reqs(1'b0, 1'b1, 0, vx, vy, nax, nay, lat);
          expect_axis(1'b1, 1'b0, vy);
        end
        2: begin
          drive_reqs(1'b1, 1'b1, 0, vx, vy, nax, nay, lat);
          expect_axis(1'b0, 1'b1, vx);
          expect_axis(1'b1, 1'b0, vy);
        end
        default: begin
          drive_reqs(1'b1, 1'b1, 10, vx, vy, nax, nay, lat);
          expect_axis(1'b0, 1'b0, vx);
          expect_axis(1'b1, 1'b0, vy);
        end
      endcase
      step(200);
      compare_frames("random");
    end

    hang = 1'b1;
    vx = 16'($urandom);
    drive_reqs(1'b1, 1'b0, 0, vx, 16'h0000, nax, nay, lat);
    expect_axis(1'b0, 1'b0, vx);
    step(5);
    t0 = last_start;
    chk("timeout_not_early", 32'(bus.err_timeout), 32'(0));
    step(TMO + 50);
    hang = 1'b0;
    chk("timeout_flag", 32'(bus.err_timeout), 32'(1));
    chk("timeout_cycles", 32'(err_rise - t0), 32'(TMO));
    compare_frames("timeout");

    vy = 16'($urandom);
    drive_reqs(1'b0, 1'b1, 0, 16'h0000, vy, nax, nay, lat);
    expect_axis(1'b1, 1'b0, vy);
    step(150);
    compare_frames("after_timeout");
    chk("timeout_sticky", 32'(bus.err_timeout), 32'(1));

    vx = 16'($urandom);
    drive_reqs(1'b1, 1'b0, 0, vx, 16'h0000, nax, nay, lat);
    expect_axis(1'b0, 1'b0, vx);
    step(20);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    rst = 1'b0;
    expect_raw(24'h280001, 2'b00);
    expect_raw(24'h380001, 2'b00);
    step(250);
    compare_frames("replay");
    check_init_timing("replay");

    chk("min_gap", 32'(min_gap >= GAP + 1), 32'(1));
    chk("data_stable", 32'(stab_err), 32'(0));
    chk("ack_with_start", 32'(ack_err), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
